design07_feeder: RTL

Transaction sequencer that sits directly upstream of `mkDesign_07`. It drives that block's `start`, `result` and `check` methods in order, one transaction at a time. A host pushes 5-bit operand pairs into a small FIFO. For each pair the feeder calls `start(a,b)`, waits for `result(c)`, forwards the result into `check(d)`, and returns the `check` value to the host. All downstream ports use BSV method semantics (`EN_`/`RDY_`).

---
 rtl/design07_feeder_pkg.sv | 22 ++
 rtl/design07_feeder_fifo.sv | 76 +++++++
 rtl/design07_feeder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/design07_feeder_pkg.sv
// ----------------------------------------------------------------------------
// design07_feeder_pkg
// Shared types and constants for the design07_feeder transaction sequencer.
//   feeder_state_t : sequencer state (ISSUE, WAIT_RES, CHECK, RESP)
//   FEEDER_W       : operand/result width of the downstream mkDesign_07
//   TXN_CNT_W      : width of the completed-transaction counter
//   WD_W           : width of the optional WAIT_RES watchdog counter
// ----------------------------------------------------------------------------
package design07_feeder_pkg;

    localparam int FEEDER_W  = 5;
    localparam int TXN_CNT_W = 8;
    localparam int WD_W      = 8;

    typedef enum logic [1:0] {
        ISSUE    = 2'd0,
        WAIT_RES = 2'd1,
        CHECK    = 2'd2,
        RESP     = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/design07_feeder_fifo.sv
// ----------------------------------------------------------------------------
// design07_feeder_fifo
// Operand-pair FIFO, 2*W bits wide and DEPTH entries deep, built as a
// read pointer, write pointer and occupancy count.
// Ports:
//   clk, srst   : clock, synchronous active-high reset (empties the FIFO)
//   push        : write push_data; ignored while full
//   push_data   : {a, b} operand pair
//   pop         : drop the head entry; ignored while empty
//   head        : current head entry (valid while !empty)
//   full, empty : occupancy flags
// A push and a pop in the same cycle are both honoured. There is no
// bypass: a pushed entry shows up on head only after the edge.
// ----------------------------------------------------------------------------
module design07_feeder_fifo #(
    parameter int W     = 5,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [2*W-1:0]   push_data,
    input  logic             pop,
    output logic [2*W-1:0]   head,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [2*W-1:0] mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q;
    logic [PW-1:0]  rd_ptr_q;
    logic [PW:0]    count_q;

    logic push_ok;
    logic pop_ok;

    assign full    = (count_q == (PW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Head must be visible in the same cycle the sequencer decides to pop,
    // so the read is asynchronous from a small register array.
    assign head = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; stale contents are never observed because
    // head is only consumed while the count says the entry is live.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/design07_feeder.sv
// ----------------------------------------------------------------------------
// design07_feeder
// Transaction sequencer in front of mkDesign_07. Host operand pairs are
// queued; for each pair the feeder calls start(a,b), waits for result(c),
// passes the result to check(d) and returns the check value to the host.
// Ports:
//   CLK, RST                 : clock, synchronous active-high reset
//   put_a, put_b, EN_put     : host push; RDY_put = FIFO not full
//   start_a, start_b,
//   EN_start, RDY_start      : downstream start method
//   result_c, result_value,
//   RDY_result               : downstream result method
//   check_d, EN_check,
//   check_value, RDY_check   : downstream check method
//   resp, resp_err,
//   resp_valid, EN_resp_take : host response handshake
//   txn_count                : completed responses, wraps 255 -> 0
// Build option: define DESIGN07_FEEDER_TIMEOUT_EN to add a WAIT_RES
// watchdog that returns resp=0, resp_err=1 after TIMEOUT cycles without
// RDY_result. Without it the feeder waits forever and resp_err is 0.
// ----------------------------------------------------------------------------
module design07_feeder
    import design07_feeder_pkg::*;
#(
    parameter int W       = FEEDER_W,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [W-1:0]         put_a,
    input  logic [W-1:0]         put_b,
    input  logic                 EN_put,
    output logic                 RDY_put,
    output logic [W-1:0]         start_a,
    output logic [W-1:0]         start_b,
    output logic                 EN_start,
    input  logic                 RDY_start,
    output logic [W-1:0]         result_c,
    input  logic [W-1:0]         result_value,
    input  logic                 RDY_result,
    output logic [W-1:0]         check_d,
    output logic                 EN_check,
    input  logic [W-1:0]         check_value,
    input  logic                 RDY_check,
    output logic [W-1:0]         resp,
    output logic                 resp_err,
    output logic                 resp_valid,
    input  logic                 EN_resp_take,
    output logic [TXN_CNT_W-1:0] txn_count
);

    feeder_state_t state_q, state_d;

    logic [W-1:0]         a_q, a_d;
    logic [W-1:0]         res_q, res_d;
    logic [W-1:0]         resp_q, resp_d;
    logic [TXN_CNT_W-1:0] txn_q, txn_d;

    logic [2*W-1:0] fifo_head;
    logic           fifo_full;
    logic           fifo_empty;

`ifdef DESIGN07_FEEDER_TIMEOUT_EN
    logic            err_q, err_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            wd_expire;

    // Fires on the TIMEOUT-th WAIT_RES cycle; a simultaneous RDY_result wins.
    assign wd_expire = (state_q == WAIT_RES) && !RDY_result &&
                       (wd_q == WD_W'(TIMEOUT - 1));
`endif

    design07_feeder_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .srst      (RST),
        .push      (EN_put),
        .push_data ({put_a, put_b}),
        .pop       (EN_start),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign RDY_put   = ~fifo_full;
    assign result_c  = a_q;
    assign check_d   = res_q;
    assign resp      = resp_q;
    assign txn_count = txn_q;

`ifdef DESIGN07_FEEDER_TIMEOUT_EN
    assign resp_err = err_q;
`else
    assign resp_err = 1'b0;
`endif

    // ---------------- state register ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ISSUE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ISSUE: begin
                if (EN_start) state_d = WAIT_RES;
            end
            WAIT_RES: begin
                if (RDY_result) state_d = CHECK;
`ifdef DESIGN07_FEEDER_TIMEOUT_EN
                else if (wd_expire) state_d = RESP;
`endif
            end
            CHECK: begin
                if (RDY_check) state_d = RESP;
            end
            RESP: begin
                if (EN_resp_take) state_d = ISSUE;
            end
            default: state_d = ISSUE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        EN_start   = 1'b0;
        EN_check   = 1'b0;
        resp_valid = 1'b0;
        start_a    = '0;
        start_b    = '0;
        unique case (state_q)
            ISSUE: begin
                EN_start = ~fifo_empty & RDY_start;
                // Only present a live head; the array itself is not reset.
                if (!fifo_empty) begin
                    start_a = fifo_head[2*W-1:W];
                    start_b = fifo_head[W-1:0];
                end
            end
            CHECK:   EN_check   = RDY_check;
            RESP:    resp_valid = 1'b1;
            default: ;
        endcase
    end

    // ---------------- datapath ----------------
    always_comb begin
        a_d    = a_q;
        res_d  = res_q;
        resp_d = resp_q;
        txn_d  = txn_q;
`ifdef DESIGN07_FEEDER_TIMEOUT_EN
        err_d  = err_q;
        wd_d   = wd_q;
`endif
        if (EN_start) begin
            a_d = fifo_head[2*W-1:W];
`ifdef DESIGN07_FEEDER_TIMEOUT_EN
            wd_d = '0;
`endif
        end
        if (state_q == WAIT_RES) begin
            if (RDY_result) begin
                res_d = result_value;
            end
`ifdef DESIGN07_FEEDER_TIMEOUT_EN
            wd_d = wd_q + WD_W'(1);
            if (wd_expire) begin
                resp_d = '0;
                err_d  = 1'b1;
            end
`endif
        end
        if (EN_check) begin
            resp_d = check_value;
`ifdef DESIGN07_FEEDER_TIMEOUT_EN
            err_d  = 1'b0;
`endif
        end
        if (resp_valid && EN_resp_take) begin
            txn_d = txn_q + TXN_CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            a_q    <= '0;
            res_q  <= '0;
            resp_q <= '0;
            txn_q  <= '0;
`ifdef DESIGN07_FEEDER_TIMEOUT_EN
            err_q  <= 1'b0;
            wd_q   <= '0;
`endif
        end else begin
            a_q    <= a_d;
            res_q  <= res_d;
            resp_q <= resp_d;
            txn_q  <= txn_d;
`ifdef DESIGN07_FEEDER_TIMEOUT_EN
            err_q  <= err_d;
            wd_q   <= wd_d;
`endif
        end
    end

endmodule
